// File: rtl/sd_data_rx.sv
// SD host DAT[3:0] receive engine: start-bit detect, nibble stream to RX FIFO, CRC16/end-bit check per block.
// Optional: define SD_RX_CRC_CHECK_EN to build the per-line CRC16 generators and comparators.
module sd_data_rx #(
    parameter int unsigned BLKSIZE_W = 12,
    parameter int unsigned BLKCNT_W  = 8,
    parameter int unsigned TOUT_W    = 16
) (
    input  logic                 wclk,
    input  logic                 rst,
    input  logic [3:0]           dat_i,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BLKSIZE_W-1:0] blksize,
    input  logic [BLKCNT_W-1:0]  blkcnt,
    input  logic [TOUT_W-1:0]    tout_val,
    input  logic                 full,
    output logic [3:0]           d,
    output logic                 wr,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_err,
    output logic                 end_err,
    output logic                 tout_err,
    output logic                 ovf
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_START = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] CRC        = 3'd3;
    localparam logic [2:0] END        = 3'd4;

    logic [2:0]           state;
    logic                 wr_q;
    logic [BLKSIZE_W-1:0] blksize_q;
    logic [BLKCNT_W-1:0]  blk_cnt;
    logic [TOUT_W-1:0]    tout_q;
    logic [TOUT_W-1:0]    tout_cnt;
    logic [BLKSIZE_W:0]   nib_cnt;
    logic [BLKSIZE_W:0]   nib_last;
    logic [3:0]           bit_cnt;
    logic                 start_ok;

    assign start_ok = (state == IDLE) && start && (blksize != '0) && (blkcnt != '0);
    assign nib_last = {blksize_q, 1'b0} - (BLKSIZE_W+1)'(1);
    assign wr       = wr_q & ~full;

    always_ff @(posedge wclk) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            wr_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            end_err   <= 1'b0;
            tout_err  <= 1'b0;
            ovf       <= 1'b0;
            blksize_q <= '0;
            blk_cnt   <= '0;
            tout_q    <= '0;
            tout_cnt  <= '0;
            nib_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            wr_q <= 1'b0;
            // The nibble presented this cycle is lost if the FIFO refuses it.
            if (wr_q && full)
                ovf <= 1'b1;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state     <= WAIT_START;
                            busy      <= 1'b1;
                            blksize_q <= blksize;
                            blk_cnt   <= blkcnt;
                            tout_q    <= tout_val;
                            tout_cnt  <= '0;
                            end_err   <= 1'b0;
                            tout_err  <= 1'b0;
                            ovf       <= 1'b0;
                        end
                    end
                    WAIT_START: begin
                        if (dat_i == 4'h0) begin
                            state   <= DATA;
                            nib_cnt <= '0;
                        end else if (tout_cnt == tout_q) begin
                            tout_err <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tout_cnt <= tout_cnt + TOUT_W'(1);
                        end
                    end
                    DATA: begin
                        d    <= dat_i;
                        wr_q <= 1'b1;
                        if (nib_cnt == nib_last) begin
                            state   <= CRC;
                            bit_cnt <= '0;
                        end else begin
                            nib_cnt <= nib_cnt + (BLKSIZE_W+1)'(1);
                        end
                    end
                    CRC: begin
                        if (bit_cnt == 4'd15)
                            state <= END;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    END: begin
                        if (dat_i != 4'hF)
                            end_err <= 1'b1;
                        blk_cnt <= blk_cnt - BLKCNT_W'(1);
                        if (blk_cnt == BLKCNT_W'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state    <= WAIT_START;
                            tout_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SD_RX_CRC_CHECK_EN
    logic [3:0][15:0] crc_q;
    logic [3:0]       crc_msb;
    logic             crc_err_q;

    assign crc_msb = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};

    // During CRC the received bits are compared against the MSB while the register drains.
    always_ff @(posedge wclk) begin
        if (rst) begin
            crc_q     <= '0;
            crc_err_q <= 1'b0;
        end else if (!abort) begin
            if (start_ok)
                crc_err_q <= 1'b0;
            case (state)
                WAIT_START: begin
                    if (dat_i == 4'h0)
                        crc_q <= '0;
                end
                DATA: begin
                    for (int unsigned i = 0; i < 4; i++)
                        crc_q[i] <= {crc_q[i][14:0], 1'b0} ^
                                    ((dat_i[i] ^ crc_q[i][15]) ? 16'h1021 : 16'h0000);
                end
                CRC: begin
                    if (dat_i != crc_msb)
                        crc_err_q <= 1'b1;
                    for (int unsigned i = 0; i < 4; i++)
                        crc_q[i] <= {crc_q[i][14:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_data_rx.sv
// Directed/randomized bench for sd_data_rx against a polynomial-division CRC16 reference.
module tb_sd_data_rx;

`ifdef SD_RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic        wclk = 1'b0;
    logic        rst, start, abort, full;
    logic [3:0]  dat_i;
    logic [11:0] blksize;
    logic [7:0]  blkcnt;
    logic [15:0] tout_val;
    logic [3:0]  d;
    logic        wr, busy, done, crc_err, end_err, tout_err, ovf;

    sd_data_rx #(.BLKSIZE_W(12), .BLKCNT_W(8), .TOUT_W(16)) dut (
        .wclk(wclk), .rst(rst), .dat_i(dat_i), .start(start), .abort(abort),
        .blksize(blksize), .blkcnt(blkcnt), .tout_val(tout_val), .full(full),
        .d(d), .wr(wr), .busy(busy), .done(done), .crc_err(crc_err),
        .end_err(end_err), .tout_err(tout_err), .ovf(ovf)
    );

    always #5 wclk = ~wclk;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] got_d[$];
    int         done_cnt = 0;

    always @(negedge wclk) begin
        if (wr) got_d.push_back(d);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge wclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, MSB first.
    function automatic logic [15:0] line_crc(input logic [3:0] nib[$], input int line);
        bit          r[$];
        logic [16:0] g = 17'h11021;
        logic [15:0] res;
        foreach (nib[k]) r.push_back(nib[k][line]);
        repeat (16) r.push_back(1'b0);
        for (int k = 0; k < nib.size(); k++)
            if (r[k])
                for (int j = 0; j <= 16; j++) r[k+j] = r[k+j] ^ g[16-j];
        for (int j = 0; j < 16; j++) res[15-j] = r[nib.size()+j];
        return res;
    endfunction

    function automatic int stream_err(input int base, input logic [3:0] exp[$]);
        int e = 0;
        if (got_d.size() - base != exp.size()) return -1;
        foreach (exp[i]) if (got_d[base+i] !== exp[i]) e++;
        return e;
    endfunction

    task automatic do_start(input int bs, input int bc, input int tv);
        blksize  = 12'(bs);
        blkcnt   = 8'(bc);
        tout_val = 16'(tv);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_block(input logic [3:0] nib[$], input int flip_line, input int full_at);
        logic [15:0] c[4];
        for (int i = 0; i < 4; i++) c[i] = line_crc(nib, i);
        dat_i = 4'h0;
        tick();
        for (int k = 0; k < nib.size(); k++) begin
            dat_i = nib[k];
            full  = (full_at >= 0) && (k >= full_at + 1) && (k <= full_at + 3);
            tick();
        end
        full = 1'b0;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 4; i++)
                dat_i[i] = (i == flip_line && b == 0) ? ~c[i][15-b] : c[i][15-b];
            tick();
        end
        dat_i = 4'hF;
        tick();
    endtask

    initial begin
        logic [3:0] nib[$];
        logic [3:0] exp[$];
        int         w0, dc0, n;
        int         gaps[3] = '{0, 5, 100};

        rst = 1'b1; start = 1'b0; abort = 1'b0; full = 1'b0; dat_i = 4'hF;
        blksize = '0; blkcnt = '0; tout_val = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_d", d, 0);
        chk("rst_wr", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {crc_err, end_err, tout_err, ovf}, 0);

        // zero block count is not a valid start
        do_start(4, 0, 100);
        tick();
        chk("zero_blkcnt_ignored", busy, 0);

        // 512-byte all-zero block
        do_start(512, 1, 100);
        chk("t1_busy", busy, 1);
        w0 = got_d.size(); dc0 = done_cnt;
        nib.delete(); exp.delete();
        repeat (1024) begin nib.push_back(4'h0); exp.push_back(4'h0); end
        send_block(nib, -1, -1);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_errs", {crc_err, end_err, tout_err, ovf}, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_wr_count", got_d.size() - w0, 1024);
        chk("t1_stream", stream_err(w0, exp), 0);
        chk("t1_done_cnt", done_cnt - dc0, 1);

        // same block with a corrupted CRC bit on DAT2
        do_start(512, 1, 100);
        w0 = got_d.size(); dc0 = done_cnt;
        send_block(nib, 2, -1);
        chk("t2_done", done, 1);
        chk("t2_crc_err", crc_err, CRC_ON);
        chk("t2_end_err", end_err, 0);
        tick();
        chk("t2_wr_count", got_d.size() - w0, 1024);
        chk("t2_done_cnt", done_cnt - dc0, 1);

        // three random 4-byte blocks with idle gaps; a start in WAIT_START must be ignored
        do_start(4, 3, 1000);
        chk("t3_crc_cleared", crc_err, 0);
        w0 = got_d.size(); dc0 = done_cnt;
        exp.delete();
        for (int b = 0; b < 3; b++) begin
            dat_i = 4'hF;
            for (int g = 0; g < gaps[b]; g++) begin
                start   = (b == 1 && g == 0);
                blkcnt  = 8'd1;
                blksize = 12'd8;
                tick();
            end
            start = 1'b0;
            nib.delete();
            repeat (8) begin
                nib.push_back(4'($urandom));
                exp.push_back(nib[$]);
            end
            send_block(nib, -1, -1);
            if (b < 2) begin
                chk("t3_mid_done", done, 0);
                chk("t3_mid_busy", busy, 1);
            end
        end
        chk("t3_done", done, 1);
        tick();
        chk("t3_errs", {crc_err, end_err, tout_err, ovf}, 0);
        chk("t3_wr_count", got_d.size() - w0, 24);
        chk("t3_stream", stream_err(w0, exp), 0);
        chk("t3_done_cnt", done_cnt - dc0, 1);

        // start-bit timeout
        do_start(4, 1, 10);
        w0 = got_d.size();
        dat_i = 4'hF;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) begin n = k; break; end
        end
        chk("t4_tout_cycle", n, 11);
        chk("t4_tout_err", tout_err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_no_wr", got_d.size() - w0, 0);

        // FIFO full for nibbles 2..4
        do_start(4, 1, 1000);
        chk("t5_tout_cleared", tout_err, 0);
        w0 = got_d.size(); dc0 = done_cnt;
        nib.delete(); exp.delete();
        for (int k = 0; k < 8; k++) begin
            nib.push_back(4'($urandom));
            if (k < 2 || k > 4) exp.push_back(nib[k]);
        end
        send_block(nib, -1, 2);
        chk("t5_done", done, 1);
        chk("t5_ovf", ovf, 1);
        tick();
        chk("t5_wr_count", got_d.size() - w0, 5);
        chk("t5_stream", stream_err(w0, exp), 0);
        chk("t5_crc_err", crc_err, 0);

        // abort after 7 nibbles, with nibble 1 dropped so ovf is set beforehand
        do_start(4, 1, 1000);
        chk("t6_ovf_cleared", ovf, 0);
        w0 = got_d.size(); dc0 = done_cnt;
        nib.delete(); exp.delete();
        dat_i = 4'h0;
        tick();
        for (int k = 0; k < 7; k++) begin
            nib.push_back(4'($urandom));
            if (k != 1) exp.push_back(nib[k]);
            dat_i = nib[k];
            full  = (k == 2);
            tick();
        end
        full  = 1'b0;
        dat_i = 4'($urandom);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        repeat (20) begin
            dat_i = 4'($urandom);
            tick();
        end
        chk("t6_wr_count", got_d.size() - w0, 6);
        chk("t6_stream", stream_err(w0, exp), 0);
        chk("t6_no_done", done_cnt - dc0, 0);
        chk("t6_ovf_kept", ovf, 1);

        do_start(4, 1, 1000);
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_ovf", ovf, 0);
        w0 = got_d.size();
        nib.delete(); exp.delete();
        repeat (8) begin
            nib.push_back(4'($urandom));
            exp.push_back(nib[$]);
        end
        send_block(nib, -1, -1);
        chk("t6_restart_done", done, 1);
        tick();
        chk("t6_restart_stream", stream_err(w0, exp), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_data_rx.md
Name: sd_data_rx

Overview:
- Receive-side data-line engine of the SD host.
- Detects the start bit on the 4-bit DAT bus, streams payload nibbles into the RX packing FIFO, checks the per-line CRC16 and end bit, and repeats for a programmed block count.
- Sits between the DAT pad sampling flops and the RX FIFO write port (d, wr, full).

Parameters:
BLKSIZE_W, 12, width of block-size field in bytes (max block 2^BLKSIZE_W-1 bytes)
BLKCNT_W, 8, width of block-count field
TOUT_W, 16, width of start-bit timeout counter

Ports:
wclk  in  1  card-side clock; all logic on rising edge
rst  in  1  synchronous active-high reset
dat_i  in  4  sampled DAT[3:0] lines
start  in  1  one-cycle pulse; arm reception
abort  in  1  one-cycle pulse; terminate transfer
blksize  in  BLKSIZE_W  bytes per block (nonzero)
blkcnt  in  BLKCNT_W  blocks to receive (nonzero)
tout_val  in  TOUT_W  max cycles to wait for start bit
full  in  1  RX FIFO full
d  out  4  nibble to FIFO
wr  out  1  FIFO write strobe
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
crc_err  out  1  sticky: CRC mismatch on any line/block
end_err  out  1  sticky: end bit not 4'hF
tout_err  out  1  sticky: start bit timeout
ovf  out  1  sticky: nibble dropped due to full

Behaviour:
- Reset: state IDLE; d=0, wr=0, busy=0, done=0, all error flags 0, counters and CRCs 0.
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE: start with blksize!=0 and blkcnt!=0 -> load block counter=blkcnt, clear all sticky flags, tout counter=0, go WAIT_START; busy=1 from the next cycle. Start with zero blksize/blkcnt is ignored. Start while busy is ignored.
- WAIT_START: dat_i==4'h0 -> DATA, nibble counter=0, the four 16-bit line CRCs=0. Otherwise increment tout counter; when it equals tout_val -> tout_err=1, done pulse, IDLE.
- DATA: every cycle sample dat_i. Registered outputs: d<=dat_i, internal wr_q<=1, giving 1-cycle latency from sample to wr.
- Per-line CRC i (poly 0x1021): fb=dat_i[i]^crc[i][15]; crc[i]<={crc[i][14:0],0}^(fb?16'h1021:0).
- Nibble counter width BLKSIZE_W+1. The last nibble is at count 2*blksize-1; then go CRC with bit counter=0.
- Output gating: wr = wr_q & ~full (combinational). If wr_q & full, the nibble is dropped and ovf<=1; the transfer continues.
- CRC: 16 cycles. Each cycle compare dat_i[i] with crc[i][15] for all i; any mismatch sets crc_err. Shift each crc left by 1. After bit 15 -> END.
- END: one cycle. dat_i!=4'hF sets end_err. Decrement block counter. If it was 1 -> done pulse, busy<=0, IDLE. Else WAIT_START with tout counter=0.
- Errors do not stop the transfer (except timeout). The host checks flags on done.
- abort: highest priority after rst, from any state. Go IDLE, wr_q<=0, busy<=0, no done pulse, sticky flags retained.
- blksize/blkcnt/tout_val are sampled only at start; later changes have no effect.
- Packing into 32-bit words is the FIFO's job. Callers keep blksize a multiple of 4; no padding is inserted.

Optional Feature:
SD_RX_CRC_CHECK_EN
- Defined: CRC generation and comparison as above.
- Undefined: CRC registers and comparators are omitted. The CRC state still consumes exactly 16 cycles, and crc_err is tied 0. All other timing is identical.

Test Plan:
- Single block, blksize=512, blkcnt=1, all-zero payload, 16 zero CRC cycles, end 4'hF -> 1024 wr pulses with d=0, crc_err=0, end_err=0, done 1 cycle after END, busy=0.
- Same block with one CRC bit on line 2 flipped -> crc_err=1, done still pulses, 1024 wr pulses.
- blkcnt=3, blksize=4, random payload with model CRC, gaps of 0/5/100 cycles between blocks -> 24 wr pulses, in-order d, one done after block 3, no errors.
- tout_val=10, dat_i held 4'hF after start -> tout_err=1 and done on the 11th WAIT_START cycle, no wr.
- full asserted for 3 nibbles mid-block -> wr low during those cycles, ovf=1, remaining nibbles written, done pulses.
- abort in DATA after 7 nibbles -> busy=0 next cycle, no done, no further wr; a new start is accepted afterwards and clears flags.
